uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver. It is the successor to the baud-tick-per-bit receiver.
- Samples each bit at mid-bit from an OVERSAMPLE×baud tick.
- Rejects glitches on the start bit.
- Supports 5–9 data bits, optional parity, and 1 or 2 stop bits.
- Delivers each word through a valid/ready handshake and reports parity, framing and overrun errors.
- Sits between the pad-side rx line and the APB UART register/FIFO logic.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_os.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and a clog2 helper
// also used by the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Smallest r with 2**r >= v, never less than 1 so it is always a legal width.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad. Resets to the idle (high)
// line level so a reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values: plain two-stage delay.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchroniser flops, idle-high on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver. Detects the start edge, confirms it at mid-bit,
// then samples every following bit at mid-bit. Completed words are offered on a
// valid/ready handshake together with parity and framing flags; a word that
// completes while the previous one is still held is dropped with an overrun pulse.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   input  logic                 os_tick,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int SW = clog2(OVERSAMPLE);
   localparam int BW = clog2(DATA_BITS + 1);

   localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] ST_LAST = BW'(STOP_BITS - 1);
   localparam logic          ODD_BIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   logic rx_s;

   rx_state_e            state_q, state_d;
   logic [SW-1:0]        scnt_q, scnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 p_err_q, p_err_d;
   logic                 f_err_q, f_err_d;
   logic                 armed_q, armed_d;
   logic                 frame_done;

   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_err_q, overrun_err_d;

   uart_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rx_s)
   );

   // Frame FSM: advances only on os_tick. The shift register fills from the top
   // so that after DATA_BITS samples the first (LSB) bit sits at bit 0.
   always_comb begin
      state_d    = state_q;
      scnt_d     = scnt_q;
      bcnt_d     = bcnt_q;
      shift_d    = shift_q;
      p_err_d    = p_err_q;
      f_err_d    = f_err_q;
      armed_d    = armed_q;
      frame_done = 1'b0;
      if (os_tick) begin
         unique case (state_q)
            IDLE: begin
               // After a low final stop bit the line must go high before
               // another start is accepted, so a break cannot retrigger.
               if (!armed_q) begin
                  if (rx_s) armed_d = 1'b1;
               end else if (!rx_s) begin
                  state_d = START;
                  scnt_d  = '0;
               end
            end
            START: begin
               if (scnt_q == SC_MID) begin
                  if (rx_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     scnt_d  = '0;
                     bcnt_d  = '0;
                     p_err_d = 1'b0;
                     f_err_d = 1'b0;
                  end
               end else begin
                  scnt_d = scnt_q + SW'(1);
               end
            end
            DATA: begin
               if (scnt_q == SC_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  scnt_d  = '0;
                  if (bcnt_q == BC_LAST) begin
                     bcnt_d  = '0;
                     state_d = (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bcnt_d = bcnt_q + BW'(1);
                  end
               end else begin
                  scnt_d = scnt_q + SW'(1);
               end
            end
            PARITY: begin
               if (scnt_q == SC_LAST) begin
                  p_err_d = (((^shift_q) ^ rx_s) != ODD_BIT);
                  scnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = STOP;
               end else begin
                  scnt_d = scnt_q + SW'(1);
               end
            end
            STOP: begin
               if (scnt_q == SC_LAST) begin
                  f_err_d = f_err_q | ~rx_s;
                  scnt_d  = '0;
                  if (bcnt_q == ST_LAST) begin
                     // Leaving at mid-stop-bit so a back-to-back start edge is
                     // seen without losing any ticks.
                     bcnt_d     = '0;
                     state_d    = IDLE;
                     armed_d    = rx_s;
                     frame_done = 1'b1;
                  end else begin
                     bcnt_d = bcnt_q + BW'(1);
                  end
               end else begin
                  scnt_d = scnt_q + SW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         scnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         p_err_q <= 1'b0;
         f_err_q <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         p_err_q <= p_err_d;
         f_err_q <= f_err_d;
         armed_q <= armed_d;
      end
   end

   // Output handshake: load a finished frame if the slot is free or being
   // emptied this cycle, otherwise keep the held word and flag the drop.
   always_comb begin
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      parity_err_d  = parity_err_q;
      frame_err_d   = frame_err_q;
      overrun_err_d = 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (frame_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d    = shift_q;
            parity_err_d = (PARITY_EN != 0) ? p_err_q : 1'b0;
            frame_err_d  = f_err_d;
            rx_valid_d   = 1'b1;
         end else begin
            overrun_err_d = 1'b1;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         parity_err_q  <= parity_err_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign parity_err  = parity_err_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: three configurations (8N1, 8E1, 7N2) share a clock and
// an os_tick at clk/4. Frames are built bit by bit on the line; expected words
// and flags come from a frame-level model of what was sent.
module tb_uart_rx_os;

   localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

   typedef struct packed {
      logic [8:0] d;
      logic       pe;
      logic       fe;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic os_tick = 1'b0;
   int   tdiv = 0;

   logic rx_a = 1'b1, ready_a = 1'b1;
   logic [7:0] data_a;
   logic valid_a, pe_a, fe_a, ov_a, busy_a;

   logic rx_p = 1'b1, ready_p = 1'b1;
   logic [7:0] data_p;
   logic valid_p, pe_p, fe_p, ov_p, busy_p;

   logic rx_c = 1'b1, ready_c = 1'b1;
   logic [6:0] data_c;
   logic valid_c, pe_c, fe_c, ov_c, busy_c;

   int checks = 0;
   int failures = 0;
   int rd_a = 0, rd_p = 0, rd_c = 0;

   obs_t qa[$], qp[$], qc[$];
   logic held_a = 1'b0, held_p = 1'b0, held_c = 1'b0;
   int   ov_cnt_a = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tdiv    <= (tdiv == 3) ? 0 : tdiv + 1;
      os_tick <= (tdiv == 3);
   end

   uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .rx_in(rx_a), .os_tick(os_tick), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun_err(ov_a), .busy(busy_a));

   uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
      .clk(clk), .rst(rst), .rx_in(rx_p), .os_tick(os_tick), .rx_data(data_p), .rx_valid(valid_p),
      .rx_ready(ready_p), .parity_err(pe_p), .frame_err(fe_p), .overrun_err(ov_p), .busy(busy_p));

   uart_rx_os #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
      .clk(clk), .rst(rst), .rx_in(rx_c), .os_tick(os_tick), .rx_data(data_c), .rx_valid(valid_c),
      .rx_ready(ready_c), .parity_err(pe_c), .frame_err(fe_c), .overrun_err(ov_c), .busy(busy_c));

   // Delivery monitors: record each newly presented word once.
   always @(negedge clk) begin
      obs_t o;
      if (valid_a && !held_a) begin
         o.d = 9'(data_a); o.pe = pe_a; o.fe = fe_a; qa.push_back(o);
      end
      held_a = valid_a && !ready_a;
      if (ov_a) ov_cnt_a++;
      if (valid_p && !held_p) begin
         o.d = 9'(data_p); o.pe = pe_p; o.fe = fe_p; qp.push_back(o);
      end
      held_p = valid_p && !ready_p;
      if (valid_c && !held_c) begin
         o.d = 9'(data_c); o.pe = pe_c; o.fe = fe_c; qc.push_back(o);
      end
      held_c = valid_c && !ready_c;
   end

   function automatic int qsize(input int w);
      case (w)
         0: return qa.size();
         1: return qp.size();
         default: return qc.size();
      endcase
   endfunction

   function automatic obs_t qget(input int w, input int idx);
      case (w)
         0: return qa[idx];
         1: return qp[idx];
         default: return qc[idx];
      endcase
   endfunction

   // Frame-level reference: what the receiver must report for a frame sent.
   function automatic obs_t model(input logic [8:0] data, input int nbits, input bit par_en,
                                  input bit odd, input logic pbit, input logic [1:0] stops,
                                  input int nstop);
      obs_t o;
      o.d  = data & ((9'd1 << nbits) - 9'd1);
      o.pe = par_en ? ((($countones(o.d) + int'(pbit)) % 2) != int'(odd)) : 1'b0;
      o.fe = 1'b0;
      for (int i = 0; i < nstop; i++) if (!stops[i]) o.fe = 1'b1;
      return o;
   endfunction

   task automatic set_line(input int w, input logic v);
      case (w)
         0: rx_a = v;
         1: rx_p = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic send_bit(input int w, input logic v);
      #1 set_line(w, v);
      repeat (BIT_CLK) @(posedge clk);
   endtask

   task automatic send_frame(input int w, input logic [8:0] data, input int nbits, input bit par_en,
                             input logic pbit, input logic [1:0] stops, input int nstop);
      send_bit(w, 1'b0);
      for (int i = 0; i < nbits; i++) send_bit(w, data[i]);
      if (par_en) send_bit(w, pbit);
      for (int i = 0; i < nstop; i++) send_bit(w, stops[i]);
   endtask

   task automatic get_word(input int w, input int idx, output bit found, output obs_t o);
      found = 1'b0;
      o = '0;
      for (int i = 0; i < 400; i++) begin
         if (qsize(w) > idx) begin
            found = 1'b1;
            o = qget(w, idx);
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({data_a, valid_a, pe_a, fe_a, ov_a, busy_a} !== 13'd0) begin
         failures++; $display("FAIL reset_a: got %h want 0", {data_a, valid_a, pe_a, fe_a, ov_a, busy_a});
      end
      checks++;
      if ({data_p, valid_p, pe_p, fe_p, ov_p, busy_p} !== 13'd0) begin
         failures++; $display("FAIL reset_p: got %h want 0", {data_p, valid_p, pe_p, fe_p, ov_p, busy_p});
      end
      checks++;
      if ({data_c, valid_c, pe_c, fe_c, ov_c, busy_c} !== 12'd0) begin
         failures++; $display("FAIL reset_c: got %h want 0", {data_c, valid_c, pe_c, fe_c, ov_c, busy_c});
      end
      @(posedge clk); #1 rst = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({valid_a, busy_a, valid_p, busy_p, valid_c, busy_c} !== 6'd0) begin
         failures++; $display("FAIL idle_after_reset: got %b want 000000",
                              {valid_a, busy_a, valid_p, busy_p, valid_c, busy_c});
      end
   endtask

   task automatic test_back_to_back;
      obs_t got, exp;
      bit found;
      int gap, rises, ov0;
      ov0 = ov_cnt_a;
      gap = 0;
      rises = 0;
      fork
         begin
            send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1);
            send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1);
         end
         begin
            int run;
            logic prev;
            run = 0;
            prev = 1'b0;
            repeat (20 * BIT_CLK) @(negedge clk) begin
               if (busy_a && !prev) begin
                  rises++;
                  if (rises > 1 && run > gap) gap = run;
               end
               if (busy_a) run = 0; else run++;
               prev = busy_a;
            end
         end
      join
      get_word(0, rd_a, found, got);
      exp = model(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1);
      checks++;
      if (!found || got !== exp) begin
         failures++; $display("FAIL b2b_w0: got d=%h pe=%b fe=%b found=%0b want d=%h pe=%b fe=%b",
                              got.d, got.pe, got.fe, found, exp.d, exp.pe, exp.fe);
      end
      get_word(0, rd_a + 1, found, got);
      exp = model(9'h03C, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1);
      checks++;
      if (!found || got !== exp) begin
         failures++; $display("FAIL b2b_w1: got d=%h pe=%b fe=%b found=%0b want d=%h pe=%b fe=%b",
                              got.d, got.pe, got.fe, found, exp.d, exp.pe, exp.fe);
      end
      rd_a += 2;
      checks++;
      if (rises != 2 || gap == 0 || gap > BIT_CLK) begin
         failures++; $display("FAIL b2b_busy_gap: got rises=%0d gap=%0d want rises=2 gap in 1..%0d",
                              rises, gap, BIT_CLK);
      end
      checks++;
      if (ov_cnt_a != ov0) begin
         failures++; $display("FAIL b2b_overrun: got %0d pulses want 0", ov_cnt_a - ov0);
      end
   endtask

   task automatic test_glitch;
      int hi;
      hi = 0;
      #1 rx_a = 1'b0;
      repeat (20) @(posedge clk);
      #1 rx_a = 1'b1;
      repeat (3 * BIT_CLK) @(negedge clk) if (busy_a) hi++;
      checks++;
      if (hi == 0 || busy_a !== 1'b0) begin
         failures++; $display("FAIL glitch_busy: got busy_cycles=%0d busy=%b want >0 and 0", hi, busy_a);
      end
      checks++;
      if (qsize(0) != rd_a) begin
         failures++; $display("FAIL glitch_no_word: got %0d words want %0d", qsize(0), rd_a);
      end
   endtask

   task automatic test_break;
      obs_t got, exp;
      bit found;
      int hi;
      hi = 0;
      send_frame(0, 9'h055, 8, 1'b0, 1'b0, 2'b00, 1);
      repeat (3 * BIT_CLK) @(negedge clk) if (busy_a) hi++;
      get_word(0, rd_a, found, got);
      exp = model(9'h055, 8, 1'b0, 1'b0, 1'b0, 2'b00, 1);
      checks++;
      if (!found || got !== exp) begin
         failures++; $display("FAIL break_word: got d=%h pe=%b fe=%b found=%0b want d=%h pe=%b fe=%b",
                              got.d, got.pe, got.fe, found, exp.d, exp.pe, exp.fe);
      end
      rd_a++;
      checks++;
      if (hi != 0 || qsize(0) != rd_a) begin
         failures++; $display("FAIL break_retrigger: got busy_cycles=%0d words=%0d want 0 and %0d",
                              hi, qsize(0), rd_a);
      end
      send_bit(0, 1'b1);
      send_frame(0, 9'h012, 8, 1'b0, 1'b0, 2'b11, 1);
      get_word(0, rd_a, found, got);
      exp = model(9'h012, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1);
      checks++;
      if (!found || got !== exp) begin
         failures++; $display("FAIL break_recover: got d=%h pe=%b fe=%b found=%0b want d=%h pe=%b fe=%b",
                              got.d, got.pe, got.fe, found, exp.d, exp.pe, exp.fe);
      end
      rd_a++;
   endtask

   task automatic test_overrun;
      int ov0;
      ov0 = ov_cnt_a;
      #1 ready_a = 1'b0;
      send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
      send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ov_cnt_a - ov0 != 1) begin
         failures++; $display("FAIL overrun_pulse: got %0d cycles want 1", ov_cnt_a - ov0);
      end
      checks++;
      if (valid_a !== 1'b1 || data_a !== 8'h11 || qsize(0) != rd_a + 1) begin
         failures++; $display("FAIL overrun_hold: got valid=%b data=%h words=%0d want 1 11 %0d",
                              valid_a, data_a, qsize(0), rd_a + 1);
      end
      rd_a++;
      @(posedge clk); #1 ready_a = 1'b1;
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b1) begin
         failures++; $display("FAIL overrun_before_accept: got valid=%b want 1", valid_a);
      end
      @(negedge clk);
      checks++;
      if (valid_a !== 1'b0) begin
         failures++; $display("FAIL overrun_accept_drop: got valid=%b want 0", valid_a);
      end
   endtask

   task automatic test_parity;
      obs_t got, exp;
      bit found;
      logic [8:0] d;
      logic pb;
      for (int i = 0; i < 8; i++) begin
         if (i < 2) begin
            d = 9'h007;
            pb = (i == 1);
         end else begin
            d = 9'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
         end
         send_frame(1, d, 8, 1'b1, pb, 2'b11, 1);
         get_word(1, rd_p, found, got);
         exp = model(d, 8, 1'b1, 1'b0, pb, 2'b11, 1);
         checks++;
         if (!found || got !== exp) begin
            failures++; $display("FAIL parity_%0d: got d=%h pe=%b fe=%b found=%0b want d=%h pe=%b fe=%b",
                                 i, got.d, got.pe, got.fe, found, exp.d, exp.pe, exp.fe);
         end
         rd_p++;
      end
   endtask

   task automatic test_random;
      obs_t got, exp;
      bit found;
      logic [8:0] d;
      logic [1:0] st;
      for (int i = 0; i < 6; i++) begin
         d = 9'($urandom_range(0, 255));
         send_frame(0, d, 8, 1'b0, 1'b0, 2'b11, 1);
         get_word(0, rd_a, found, got);
         exp = model(d, 8, 1'b0, 1'b0, 1'b0, 2'b11, 1);
         checks++;
         if (!found || got !== exp) begin
            failures++; $display("FAIL rand_8n1_%0d: got d=%h fe=%b found=%0b want d=%h fe=%b",
                                 i, got.d, got.fe, found, exp.d, exp.fe);
         end
         rd_a++;
      end
      for (int i = 0; i < 8; i++) begin
         d = 9'($urandom_range(0, 127));
         st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
         send_frame(2, d, 7, 1'b0, 1'b0, st, 2);
         send_bit(2, 1'b1);
         get_word(2, rd_c, found, got);
         exp = model(d, 7, 1'b0, 1'b0, 1'b0, st, 2);
         checks++;
         if (!found || got !== exp) begin
            failures++; $display("FAIL rand_7n2_%0d: got d=%h fe=%b found=%0b want d=%h fe=%b",
                                 i, got.d, got.fe, found, exp.d, exp.fe);
         end
         rd_c++;
      end
   endtask

   task automatic test_reset_midframe;
      obs_t got, exp;
      bit found;
      logic [8:0] d;
      #1 ready_c = 1'b0;
      send_frame(2, 9'h05A, 7, 1'b0, 1'b0, 2'b11, 2);
      get_word(2, rd_c, found, got);
      exp = model(9'h05A, 7, 1'b0, 1'b0, 1'b0, 2'b11, 2);
      checks++;
      if (!found || got !== exp || valid_c !== 1'b1) begin
         failures++; $display("FAIL rstmf_first: got d=%h fe=%b valid=%b found=%0b want d=%h fe=%b valid=1",
                              got.d, got.fe, valid_c, found, exp.d, exp.fe);
      end
      rd_c++;
      send_bit(2, 1'b0);
      send_bit(2, 1'b1);
      send_bit(2, 1'b0);
      #1 rx_c = 1'b1;
      repeat (20) @(posedge clk);
      checks++;
      if (busy_c !== 1'b1) begin
         failures++; $display("FAIL rstmf_inframe: got busy=%b want 1", busy_c);
      end
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({data_c, valid_c, pe_c, fe_c, ov_c, busy_c} !== 12'd0) begin
         failures++; $display("FAIL rstmf_outputs: got %h want 0", {data_c, valid_c, pe_c, fe_c, ov_c, busy_c});
      end
      ready_c = 1'b1;
      @(posedge clk); #1 rst = 1'b1;
      repeat (2 * BIT_CLK) @(posedge clk);
      checks++;
      if (busy_c !== 1'b0 || qsize(2) != rd_c) begin
         failures++; $display("FAIL rstmf_aborted: got busy=%b words=%0d want 0 %0d", busy_c, qsize(2), rd_c);
      end
      d = 9'($urandom_range(0, 127));
      send_frame(2, d, 7, 1'b0, 1'b0, 2'b11, 2);
      get_word(2, rd_c, found, got);
      exp = model(d, 7, 1'b0, 1'b0, 1'b0, 2'b11, 2);
      checks++;
      if (!found || got !== exp) begin
         failures++; $display("FAIL rstmf_after: got d=%h fe=%b found=%0b want d=%h fe=%b",
                              got.d, got.fe, found, exp.d, exp.fe);
      end
      rd_c++;
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_glitch;
      test_break;
      test_overrun;
      test_parity;
      test_random;
      test_reset_midframe;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
